// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- iterative unsigned multiply / divide unit (MUL, MULHU, DIVU,
// REMU) for the execute stage. One shared add/sub datapath (`adder`) is
// sequenced over ITERS iterations, one per clock.
//
// Handshake: start is sampled only in IDLE. busy is high while an operation
// is in flight (RUN and DONE); done is a one-cycle pulse during which result
// is valid. result is held until the next accepted start. There is no
// back-pressure: the core stalls on busy and captures result on done.
//
// Ports (module muldiv_seq):
//   clk     in   1     core clock, rising edge
//   rst     in   1     asynchronous active-high reset
//   start   in   1     operation request (IDLE only)
//   op      in   2     00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a       in   XLEN  multiplicand / dividend
//   b       in   XLEN  multiplier / divisor
//   busy    out  1     operation in flight
//   done    out  1     result-valid pulse
//   result  out  XLEN  selected result
//
// Ports (module adder): a, b, sub, o -- o = a + b (sub=0) or a - b (sub=1).
// ---------------------------------------------------------------------------

module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] o
);
  // Two's-complement subtract: invert b and inject a carry-in of 1.
  assign o = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
endmodule

module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW   = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hi;     // product high word / partial remainder
  logic [XLEN-1:0] r_lo;     // multiplier then product low word / dividend then quotient
  logic [XLEN-1:0] r_d;      // multiplicand / divisor
  logic [1:0]      r_op_q;

  logic            w_is_div;
  logic [XLEN-1:0] w_rem_sh;
  logic            w_msb;
  logic [XLEN-1:0] w_add_a;
  logic [XLEN-1:0] w_add_o;
  logic            w_add_sub;
  logic [XLEN-1:0] w_y;
  logic            w_cout;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_res_nxt;

  assign w_is_div  = r_op_q[1];
  // Restoring divide works on the remainder shifted left by one with the next
  // dividend bit brought in; the bit shifted out of hi is kept as w_msb.
  assign w_rem_sh  = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  assign w_msb     = r_hi[XLEN-1];
  assign w_add_a   = w_is_div ? w_rem_sh : r_hi;
  assign w_add_sub = w_is_div;

  adder #(.W(XLEN)) u_adder (
    .a   (w_add_a),
    .b   (r_d),
    .sub (w_add_sub),
    .o   (w_add_o)
  );

  // Carry out of the top bit, recovered from the operand and sum MSBs. For a
  // subtract it is the "no borrow" flag, i.e. w_add_a >= r_d.
  assign w_y    = r_d ^ {XLEN{w_add_sub}};
  assign w_cout = (w_add_a[XLEN-1] & w_y[XLEN-1]) |
                  ((w_add_a[XLEN-1] | w_y[XLEN-1]) & ~w_add_o[XLEN-1]);

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_is_div) begin
      // A set w_msb means the shifted remainder exceeds 2^XLEN > divisor, so
      // the subtract always succeeds and its wrapped result is exact.
      if (w_msb | w_cout) begin
        w_hi_nxt = w_add_o;
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rem_sh;
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add, LSB first: the sum's carry becomes the new hi MSB.
      if (r_lo[0]) begin
        w_hi_nxt = {w_cout, w_add_o[XLEN-1:1]};
        w_lo_nxt = {w_add_o[0], r_lo[XLEN-1:1]};
      end else begin
        w_hi_nxt = {1'b0, r_hi[XLEN-1:1]};
        w_lo_nxt = {r_hi[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // MULHU/REMU take hi, MUL/DIVU take lo. Selected from the final-iteration
  // next values so result is registered on the same edge that enters DONE.
  assign w_res_nxt = r_op_q[0] ? w_hi_nxt : w_lo_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
      r_op_q  <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op_q  <= op;
            r_count <= '0;
            r_hi    <= '0;
            if (op[1]) begin
              r_d  <= b;
              r_lo <= a;
            end else begin
              r_d  <= a;
              r_lo <= b;
            end
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            done    <= 1'b1;
            result  <= w_res_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide unit for the M-extension path: MUL, MULHU, DIVU, REMU.
- Contains exactly one instance of the shared 32-bit add/sub datapath, `adder` (ports a, b, sub, o), and sequences it over 32 iterations, one per cycle.
- Sits beside the ALU in the execute stage. The core stalls on busy and captures result on done.

Parameters:
- XLEN, 32, operand/result width; fixed to 32 (matches adder width).
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=MUL (low word), 01=MULHU (high word), 10=DIVU (quotient), 11=REMU (remainder).
- a  input  32  multiplicand / dividend; sampled with start.
- b  input  32  multiplier / divisor; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  selected result; held until next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, hi=lo=0, op_q=0, busy=0, done=0, result=0. Reset asserted mid-operation aborts it with no done pulse.
- FSM states are IDLE, RUN and DONE.
  - IDLE + start: latch op_q=op, divisor/multiplicand register d=a (mul) or b (div), count=0, and go to RUN. For mul, set hi=0, lo=b. For div, set hi=0 (remainder), lo=a (dividend/quotient).
  - IDLE with no start: stay in IDLE.
  - RUN: perform one iteration per cycle, count++. After iteration count==31 (32nd iteration), go to DONE.
  - DONE: done=1 for exactly this cycle and result is written. Return unconditionally to IDLE.
- start is ignored in RUN and DONE. An accepted start at edge N gives done high in the cycle after edge N+32, so throughput is one op per 34 cycles.
- Operand capture: a and b are sampled only at the accepting edge. Later changes to a or b have no effect.
- Adder usage, multiply (shift-add, LSB first):
  - adder.a=hi, adder.b=d, sub=0.
  - If lo[0]=1, {c,hi,lo} <= {cout, o, lo} >> 1. Otherwise {hi,lo} <= {0, hi, lo} >> 1.
- Adder usage, divide (restoring):
  - Form the shifted remainder r'={hi[30:0], lo[31]}, keeping msb=hi[31].
  - adder.a=r', adder.b=d, sub=1.
  - If msb=1 or cout=1 (r'>=d): hi<=o and quotient bit=1. Otherwise hi<=r' and quotient bit=0.
  - Update lo<={lo[30:0], qbit}.
- Carry-out: the adder has no carry port, so derive it as cout = (x31 & y31) | ((x31 | y31) & ~o31), where x=adder.a and y=b^{32{sub}}.
- Result select in DONE: MUL=lo, MULHU=hi, DIVU=lo, REMU=hi.
- Divide by zero: no special case. The algorithm must naturally yield DIVU=0xFFFFFFFF and REMU=a (RISC-V semantics).
- Overflow: MUL returns the low 32 bits of the 64-bit product. No exceptions or flags.
- The adder inputs are driven combinationally from registers in every state. Its output is only consumed in RUN.

Test Plan:
- MUL a=7, b=6, start pulsed one cycle in IDLE -> busy=1 next cycle; done=1 exactly 33 cycles after the start edge with result=0x0000002A; busy=0 the following cycle.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. The same operands with MUL -> result=0x00000001.
- DIVU a=100, b=7 -> result=14. REMU with the same operands -> result=2. DIVU a=0x80000000, b=1 -> result=0x80000000.
- Divide by zero: DIVU a=0x1234, b=0 -> result=0xFFFFFFFF; REMU a=0x1234, b=0 -> result=0x00001234.
- start re-pulsed with different operands during RUN and during DONE, and a/b changed mid-operation -> ignored; a single done pulse with the original result. The next start in IDLE is accepted normally.
- rst asserted asynchronously during RUN (iteration 10) -> busy, done and result go to 0 immediately; no done pulse. After release, MUL 3*5 completes with result=15 at +33 cycles.
